persp_param_sequencer: RTL and testbench

Sequences the perspective-parameter datapath (`perspective_params`). Accepts corner-point sets from the corner detector and range-checks them. Applies an accepted set to the datapath only at a frame boundary. It then waits a fixed settle window, because the datapath is a deep combinational multiply chain timed as a multicycle path. Finally it emits a one-cycle commit strobe so downstream pixel-mapping logic latches the inverse parameters between frames, never mid-frame.

---
 rtl/persp_pkg.sv | 35 +++
 rtl/corner_range_check.sv | 24 ++
 rtl/persp_param_sequencer.sv | 138 +++++++++++++
 tb/tb_persp_param_sequencer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/persp_pkg.sv
// Shared types and constants for the perspective-parameter sequencer:
// FSM states, screen geometry, coordinate widths and default corner placement.
package persp_pkg;

  localparam int XW = 10;
  localparam int YW = 9;

  localparam int SCREEN_W     = 640;
  localparam int SCREEN_H     = 480;
  localparam int SCREEN_MAX_X = SCREEN_W - 1;
  localparam int SCREEN_MAX_Y = SCREEN_H - 1;

  // Bit i describes corner i+1: corners 2,3 sit on the right edge, 3,4 on the bottom.
  localparam logic [3:0] DEF_X_AT_MAX = 4'b0110;
  localparam logic [3:0] DEF_Y_AT_MAX = 4'b1100;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    COMMIT
  } state_t;

  function automatic logic [3:0][XW-1:0] default_x(input int max_x);
    logic [3:0][XW-1:0] res;
    for (int i = 0; i < 4; i++) res[i] = DEF_X_AT_MAX[i] ? XW'(max_x) : '0;
    return res;
  endfunction

  function automatic logic [3:0][YW-1:0] default_y(input int max_y);
    logic [3:0][YW-1:0] res;
    for (int i = 0; i < 4; i++) res[i] = DEF_Y_AT_MAX[i] ? YW'(max_y) : '0;
    return res;
  endfunction

endpackage

// File: rtl/corner_range_check.sv
// Combinational legality check on a set of four corner points against the
// screen bounds; in_range is high only when every coordinate is legal.
module corner_range_check
  import persp_pkg::*;
#(
  parameter int MAX_X = SCREEN_MAX_X,
  parameter int MAX_Y = SCREEN_MAX_Y
) (
  input  logic [3:0][XW-1:0] x,
  input  logic [3:0][YW-1:0] y,
  output logic               in_range
);

  logic [3:0] ok;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_corner
      assign ok[gi] = (x[gi] <= XW'(MAX_X)) && (y[gi] <= YW'(MAX_Y));
    end
  endgenerate

  assign in_range = &ok;

endmodule

// File: rtl/persp_param_sequencer.sv
// Captures range-checked corner sets, applies one to the perspective datapath at a
// frame boundary, waits out the multicycle settle window, then strobes params_load.
module persp_param_sequencer
  import persp_pkg::*;
#(
  parameter int SETTLE_CYCLES = 8,
  parameter int MAX_X         = SCREEN_MAX_X,
  parameter int MAX_Y         = SCREEN_MAX_Y
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          frame_start,
  input  logic          freeze,
  input  logic          pts_valid,
  input  logic [XW-1:0] x1_in,
  input  logic [XW-1:0] x2_in,
  input  logic [XW-1:0] x3_in,
  input  logic [XW-1:0] x4_in,
  input  logic [YW-1:0] y1_in,
  input  logic [YW-1:0] y2_in,
  input  logic [YW-1:0] y3_in,
  input  logic [YW-1:0] y4_in,
  output logic [XW-1:0] x1,
  output logic [XW-1:0] x2,
  output logic [XW-1:0] x3,
  output logic [XW-1:0] x4,
  output logic [YW-1:0] y1,
  output logic [YW-1:0] y2,
  output logic [YW-1:0] y3,
  output logic [YW-1:0] y4,
  output logic          params_load,
  output logic          params_ready,
  output logic          busy,
  output logic [7:0]    reject_count
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);

  logic [3:0][XW-1:0] x_in;
  logic [3:0][YW-1:0] y_in;
  logic               in_range;

  assign x_in = {x4_in, x3_in, x2_in, x1_in};
  assign y_in = {y4_in, y3_in, y2_in, y1_in};

  corner_range_check #(
    .MAX_X(MAX_X),
    .MAX_Y(MAX_Y)
  ) u_range_check (
    .x       (x_in),
    .y       (y_in),
    .in_range(in_range)
  );

  state_t             state_reg, state_next;
  logic [CW-1:0]      cnt_reg;
  logic [3:0][XW-1:0] pend_x_reg;
  logic [3:0][YW-1:0] pend_y_reg;
  logic               pend_valid_reg;
  logic [3:0][XW-1:0] corner_x_reg;
  logic [3:0][YW-1:0] corner_y_reg;
  logic               ready_reg;
  logic [7:0]         reject_reg;
  logic               apply;
  logic               capture;
  logic               reject;

  assign capture = pts_valid & in_range;
  assign reject  = pts_valid & ~in_range;

  always_comb begin
    state_next = state_reg;
    apply      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (frame_start && pend_valid_reg && !freeze) begin
          state_next = SETTLE;
          apply      = 1'b1;
        end
      end
      SETTLE:  if (cnt_reg == '0) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      pend_x_reg     <= '0;
      pend_y_reg     <= '0;
      pend_valid_reg <= 1'b0;
      corner_x_reg   <= default_x(MAX_X);
      corner_y_reg   <= default_y(MAX_Y);
      ready_reg      <= 1'b0;
      reject_reg     <= '0;
    end else begin
      state_reg <= state_next;

      if (apply) begin
        cnt_reg      <= CW'(SETTLE_CYCLES - 1);
        corner_x_reg <= pend_x_reg;
        corner_y_reg <= pend_y_reg;
      end else if (state_reg == SETTLE && cnt_reg != '0) begin
        cnt_reg <= cnt_reg - 1'b1;
      end

      // A set arriving on the apply edge is kept for the next frame.
      if (capture) begin
        pend_x_reg     <= x_in;
        pend_y_reg     <= y_in;
        pend_valid_reg <= 1'b1;
      end else if (apply) begin
        pend_valid_reg <= 1'b0;
      end

      if (reject && reject_reg != 8'hFF) reject_reg <= reject_reg + 8'd1;

      if (state_reg == COMMIT) ready_reg <= 1'b1;
    end
  end

  assign params_load  = (state_reg == COMMIT);
  assign busy         = (state_reg != IDLE);
  assign params_ready = ready_reg;
  assign reject_count = reject_reg;

  assign x1 = corner_x_reg[0];
  assign x2 = corner_x_reg[1];
  assign x3 = corner_x_reg[2];
  assign x4 = corner_x_reg[3];
  assign y1 = corner_y_reg[0];
  assign y2 = corner_y_reg[1];
  assign y3 = corner_y_reg[2];
  assign y4 = corner_y_reg[3];

endmodule

// File: tb/tb_persp_param_sequencer.sv
// Directed, table-driven bench for persp_param_sequencer: a vector table of corner
// sets with hand-marked accept/reject, plus hand-written multi-cycle sequences.
module tb_persp_param_sequencer;

  typedef struct {
    logic [3:0][9:0] xs;
    logic [3:0][8:0] ys;
    bit              accept;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_start = 1'b0;
  logic       freeze = 1'b0;
  logic       pts_valid = 1'b0;
  logic [9:0] x1_in = '0, x2_in = '0, x3_in = '0, x4_in = '0;
  logic [8:0] y1_in = '0, y2_in = '0, y3_in = '0, y4_in = '0;
  logic [9:0] x1, x2, x3, x4;
  logic [8:0] y1, y2, y3, y4;
  logic       params_load, params_ready, busy;
  logic [7:0] reject_count;

  int tests = 0;
  int fails = 0;

  logic [3:0][9:0] exp_x;
  logic [3:0][8:0] exp_y;
  int              exp_rej;
  bit              exp_ready;

  persp_param_sequencer dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .freeze(freeze),
    .pts_valid(pts_valid),
    .x1_in(x1_in), .x2_in(x2_in), .x3_in(x3_in), .x4_in(x4_in),
    .y1_in(y1_in), .y2_in(y2_in), .y3_in(y3_in), .y4_in(y4_in),
    .x1(x1), .x2(x2), .x3(x3), .x4(x4),
    .y1(y1), .y2(y2), .y3(y3), .y4(y4),
    .params_load(params_load), .params_ready(params_ready), .busy(busy),
    .reject_count(reject_count)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input int ax1, input int ay1, input int ax2, input int ay2,
                              input int ax3, input int ay3, input int ax4, input int ay4,
                              input bit acc);
    vec_t v;
    v.xs[0] = 10'(ax1); v.xs[1] = 10'(ax2); v.xs[2] = 10'(ax3); v.xs[3] = 10'(ax4);
    v.ys[0] = 9'(ay1);  v.ys[1] = 9'(ay2);  v.ys[2] = 9'(ay3);  v.ys[3] = 9'(ay4);
    v.accept = acc;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic chk_corners(input string name);
    logic [3:0][9:0] xo;
    logic [3:0][8:0] yo;
    xo = {x4, x3, x2, x1};
    yo = {y4, y3, y2, y1};
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s x%0d", name, i + 1), int'(xo[i]), int'(exp_x[i]));
      chk($sformatf("%s y%0d", name, i + 1), int'(yo[i]), int'(exp_y[i]));
    end
  endtask

  task automatic set_defaults();
    exp_x = {10'd0, 10'd639, 10'd639, 10'd0};
    exp_y = {9'd479, 9'd479, 9'd0, 9'd0};
  endtask

  task automatic drive_set(input vec_t v);
    x1_in = v.xs[0]; x2_in = v.xs[1]; x3_in = v.xs[2]; x4_in = v.xs[3];
    y1_in = v.ys[0]; y2_in = v.ys[1]; y3_in = v.ys[2]; y4_in = v.ys[3];
  endtask

  task automatic send(input vec_t v);
    drive_set(v);
    pts_valid = 1'b1;
    step();
    pts_valid = 1'b0;
  endtask

  // k counts edges after the frame_start edge T; commit cycle follows edge T+8.
  task automatic run_frame(input string name, input bit commit);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) step();
      chk($sformatf("%s load k=%0d", name, k), int'(params_load), int'(commit && k == 8));
      chk($sformatf("%s busy k=%0d", name, k), int'(busy), int'(commit && k <= 8));
      if (k == 0) chk_corners($sformatf("%s k0", name));
    end
    if (commit) exp_ready = 1'b1;
    chk_corners($sformatf("%s end", name));
    chk($sformatf("%s ready", name), int'(params_ready), int'(exp_ready));
    $display("[TB] frame %s commit=%0d corners=(%0d,%0d)(%0d,%0d)(%0d,%0d)(%0d,%0d)",
             name, commit, x1, y1, x2, y2, x3, y3, x4, y4);
  endtask

  vec_t vecs[7];
  vec_t va, vb, vc, vd, ve, vf;

  initial begin
    vecs[0] = mk(100, 50, 540, 60, 530, 420, 110, 430, 1'b1);
    vecs[1] = mk(100, 50, 540, 60, 640, 420, 110, 430, 1'b0);
    vecs[2] = mk(639, 479, 639, 479, 639, 479, 639, 479, 1'b1);
    vecs[3] = mk(10, 10, 20, 480, 30, 30, 40, 40, 1'b0);
    vecs[4] = mk(0, 0, 5, 6, 7, 8, 9, 1, 1'b1);
    vecs[5] = mk(1023, 0, 0, 0, 0, 0, 0, 0, 1'b0);
    vecs[6] = mk(0, 511, 0, 0, 0, 0, 0, 0, 1'b0);
    va = mk(11, 12, 13, 14, 15, 16, 17, 18, 1'b1);
    vb = mk(200, 100, 400, 110, 410, 300, 190, 310, 1'b1);
    vc = mk(1, 2, 3, 4, 5, 6, 7, 8, 1'b1);
    vd = mk(21, 22, 23, 24, 25, 26, 27, 28, 1'b1);
    ve = mk(31, 32, 33, 34, 35, 36, 37, 38, 1'b1);
    vf = mk(41, 42, 43, 44, 45, 46, 47, 48, 1'b1);

    set_defaults();
    exp_rej   = 0;
    exp_ready = 1'b0;

    // Reset state, checked while reset is still held and after release.
    step();
    step();
    chk_corners("rst held");
    chk("rst load", int'(params_load), 0);
    chk("rst busy", int'(busy), 0);
    reset = 1'b0;
    step();
    chk_corners("rst rel");
    chk("rst ready", int'(params_ready), 0);
    chk("rst rej", int'(reject_count), 0);
    for (int f = 0; f < 3; f++) run_frame($sformatf("idle%0d", f), 1'b0);

    // Table-driven sets: each is offered, then one frame is run.
    for (int i = 0; i < 7; i++) begin
      send(vecs[i]);
      if (!vecs[i].accept) exp_rej++;
      chk($sformatf("vec%0d rej", i), int'(reject_count), exp_rej);
      if (vecs[i].accept) begin
        exp_x = vecs[i].xs;
        exp_y = vecs[i].ys;
      end
      run_frame($sformatf("vec%0d", i), vecs[i].accept);
    end

    // Saturation of the reject counter.
    for (int i = 0; i < 300; i++) begin
      drive_set(vecs[1]);
      pts_valid = 1'b1;
      step();
    end
    pts_valid = 1'b0;
    chk("sat rej", int'(reject_count), 255);
    $display("[TB] saturation reject_count=%0d", reject_count);
    run_frame("sat", 1'b0);

    // Set B and a second frame_start arrive during SETTLE of set A.
    send(va);
    exp_x = va.xs;
    exp_y = va.ys;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) step();
      chk($sformatf("ab load k=%0d", k), int'(params_load), int'(k == 8));
      chk($sformatf("ab busy k=%0d", k), int'(busy), int'(k <= 8));
      chk_corners($sformatf("ab k=%0d", k));
      pts_valid   = (k == 2);
      frame_start = (k == 4);
      if (k == 2) drive_set(vb);
    end
    pts_valid   = 1'b0;
    frame_start = 1'b0;
    $display("[TB] frame ab applied A, B pending");
    exp_x = vb.xs;
    exp_y = vb.ys;
    run_frame("ab-B", 1'b1);

    // Freeze holds off application across two frames.
    send(vc);
    freeze = 1'b1;
    run_frame("frz0", 1'b0);
    run_frame("frz1", 1'b0);
    freeze = 1'b0;
    exp_x = vc.xs;
    exp_y = vc.ys;
    run_frame("frz-rel", 1'b1);

    // Capture on the apply edge: D applied now, E retained for the next frame.
    send(vd);
    drive_set(ve);
    pts_valid   = 1'b1;
    frame_start = 1'b1;
    step();
    pts_valid   = 1'b0;
    frame_start = 1'b0;
    exp_x = vd.xs;
    exp_y = vd.ys;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) step();
      chk($sformatf("de load k=%0d", k), int'(params_load), int'(k == 8));
      if (k == 0 || k == 11) chk_corners($sformatf("de k=%0d", k));
    end
    $display("[TB] frame de applied D, E pending");
    exp_x = ve.xs;
    exp_y = ve.ys;
    run_frame("de-E", 1'b1);

    // Reset three cycles into SETTLE aborts the sequence.
    send(vf);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    step();
    step();
    step();
    reset = 1'b1;
    #1;
    set_defaults();
    exp_ready = 1'b0;
    exp_rej   = 0;
    chk_corners("abort held");
    chk("abort busy", int'(busy), 0);
    step();
    chk("abort load", int'(params_load), 0);
    step();
    reset = 1'b0;
    chk("abort ready", int'(params_ready), 0);
    chk("abort rej", int'(reject_count), 0);
    for (int k = 0; k < 12; k++) begin
      step();
      chk($sformatf("abort load k=%0d", k), int'(params_load), 0);
    end
    $display("[TB] abort sequence done");
    run_frame("post-abort", 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
